iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a power of two and >= 4.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per clock; SHALL satisfy 1 <= STEP <= WIDTH.
REQ-003 Derived SHAMT_W = $clog2(WIDTH)+1: shift-amount width; legal amounts are 0..2*WIDTH-1.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 flush  input  1  synchronous abort of any operation in flight.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block accepts a request this cycle.
REQ-009 in_data  input  WIDTH  operand.
REQ-010 in_amt  input  SHAMT_W  shift amount.
REQ-011 in_dir  input  1  0 = left (toward bit WIDTH-1), 1 = right (toward bit 0).
REQ-012 in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes result this cycle.
REQ-015 out_data  output  WIDTH  result; meaningful only while out_valid = 1.

Function
REQ-016 States SHALL be IDLE, SHIFT, DONE; in_ready = (state == IDLE) && !flush; out_valid = (state == DONE).
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready; operand, amount, direction and mode are captured then; later input changes have no effect.
REQ-018 Effective amount E: rotate -> in_amt mod WIDTH; logical/arithmetic -> min(in_amt, WIDTH).
REQ-019 Mode 11 SHALL behave exactly as logical.
REQ-020 Logical: vacated bits filled with 0. Arithmetic right: vacated bits filled with captured in_data[WIDTH-1]. Arithmetic left: identical to logical left. Rotate: bits leaving one end re-enter at the other.
REQ-021 N = ceil(E/STEP); each SHIFT cycle shifts by min(remaining, STEP); remaining count decrements by that amount.
REQ-022 On accept: if N = 0 go to DONE with out_data = in_data; else go to SHIFT with working register loaded.
REQ-023 SHIFT -> DONE on the edge performing the final step; accept in cycle c SHALL give out_valid high from cycle c+1+N.
REQ-024 DONE holds out_data and out_valid stable until out_valid && out_ready, then -> IDLE; no new request is accepted in the same cycle (in_ready low in DONE).
REQ-025 Arithmetic right with E = WIDTH SHALL yield all bits equal to the sign bit; logical with E = WIDTH SHALL yield 0.
REQ-026 out_data MAY change during SHIFT (working register); it SHALL NOT change while out_valid = 1.
REQ-027 flush = 1 in any state SHALL force IDLE on that edge, discard the operation, and block acceptance that cycle; out_data retains its value.
REQ-028 rst has priority over flush and all other inputs.

Reset
REQ-029 On rst = 1 at a rising edge: state = IDLE, out_valid = 0, out_data = 0, remaining count = 0, captured mode/dir = 0.
REQ-030 in_ready SHALL be 0 while rst is asserted and 1 in the first cycle after release (flush low).
REQ-031 rst asserted mid-SHIFT or in DONE SHALL abandon the operation; no out_valid pulse follows.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-032 in_data=8'hAD, amt=2, dir=0, mode=00, out_ready=1 -> out_data=8'hB4, out_valid high cycle c+3, one cycle, then in_ready=1.
REQ-033 in_data=8'hAD, amt=2, dir=1, mode=01 -> 8'hEB at c+3; same with mode=00 -> 8'h2B; mode=11 -> 8'h2B.
REQ-034 in_data=8'hAD, amt=9, dir=1, mode=10 -> 8'hD6 at c+2; amt=0 any mode -> 8'hAD at c+1; amt=12, dir=1, mode=00 -> 8'h00 at c+9; mode=01 -> 8'hFF at c+9.
REQ-035 out_ready held 0 for 4 cycles after out_valid -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 flush in second SHIFT cycle of amt=5 request -> IDLE next cycle, no out_valid; simultaneous flush and in_valid in IDLE -> not accepted; rst mid-SHIFT -> all outputs to reset values.
REQ-037 STEP=3: in_data=8'h01, amt=7, dir=0, mode=00 -> 8'h80 at c+4 (steps 3,3,1).

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle barrel shifter: a request is captured, shifted by up to STEP bits per clock,
// and the result is held until the consumer takes it. Logical, arithmetic and rotate modes.
module iter_shifter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_data_i,
  input  logic [SHAMT_W-1:0] in_amt_i,
  input  logic               in_dir_i,
  input  logic [1:0]         in_mode_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o
);

  localparam int unsigned LogW = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] WidthAmt = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] StepAmt  = SHAMT_W'(STEP);

  localparam logic [1:0] ModeLogical = 2'b00;
  localparam logic [1:0] ModeArith   = 2'b01;
  localparam logic [1:0] ModeRotate  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;

  logic [SHAMT_W-1:0] eff_amt;
  logic [SHAMT_W-1:0] step_amt;
  logic [WIDTH-1:0]   step_result;

  // One shift step of k bits (k <= WIDTH); a double-width vector supplies the fill bits.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0]   d,
                                                  input logic [SHAMT_W-1:0] k,
                                                  input logic               dir,
                                                  input logic [1:0]         mode);
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH-1:0]   fill;
    logic [WIDTH-1:0]   res;
    fill = '0;
    ext  = '0;
    if (mode == ModeRotate) begin
      if (dir) begin
        ext = {d, d} >> k;
        res = ext[WIDTH-1:0];
      end else begin
        ext = {d, d} << k;
        res = ext[2*WIDTH-1:WIDTH];
      end
    end else begin
      if ((mode == ModeArith) && dir) begin
        fill = {WIDTH{d[WIDTH-1]}};
      end
      if (dir) begin
        ext = {fill, d} >> k;
        res = ext[WIDTH-1:0];
      end else begin
        ext = {d, {WIDTH{1'b0}}} << k;
        res = ext[2*WIDTH-1:WIDTH];
      end
    end
    return res;
  endfunction

  // Rotation wraps modulo WIDTH; shifts saturate at WIDTH (reserved mode acts as logical).
  always_comb begin
    eff_amt = '0;
    if (in_mode_i == ModeRotate) begin
      eff_amt = {{(SHAMT_W - LogW){1'b0}}, in_amt_i[LogW-1:0]};
    end else if (in_amt_i > WidthAmt) begin
      eff_amt = WidthAmt;
    end else begin
      eff_amt = in_amt_i;
    end
  end

  always_comb begin
    step_amt    = (rem_q < StepAmt) ? rem_q : StepAmt;
    step_result = shift_step(data_q, step_amt, dir_q, mode_q);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;

    if (flush_i) begin
      state_d = StIdle;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            data_d  = in_data_i;
            dir_d   = in_dir_i;
            mode_d  = in_mode_i;
            rem_d   = eff_amt;
            state_d = (eff_amt == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          data_d = step_result;
          rem_d  = rem_q - step_amt;
          if (rem_q <= StepAmt) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  // rst gates in_ready so nothing looks acceptable while reset is held.
  assign in_ready_o  = (state_q == StIdle) && !flush_i && !rst_i;
  assign out_valid_o = (state_q == StDone);
  assign out_data_o  = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: a STEP=1 and a STEP=3 instance share stimulus and are compared
// against an arithmetic reference of the shift rules and of the expected latency.
module tb_iter_shifter;

  localparam int W  = 8;
  localparam int SW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_dir, out_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic [1:0]    in_mode;
  logic          a_ready, a_valid, b_ready, b_valid;
  logic [W-1:0]  a_data, b_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_ready),
    .in_data_i(in_data), .in_amt_i(in_amt), .in_dir_i(in_dir), .in_mode_i(in_mode),
    .out_valid_o(a_valid), .out_ready_i(out_ready), .out_data_o(a_data)
  );

  iter_shifter #(.WIDTH(W), .STEP(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_ready),
    .in_data_i(in_data), .in_amt_i(in_amt), .in_dir_i(in_dir), .in_mode_i(in_mode),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .out_data_o(b_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_amt(input int amt, input int mode);
    if (mode == 2) return amt % W;
    return (amt > W) ? W : amt;
  endfunction

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int amt,
                                             input bit dir, input int mode);
    int e;
    logic signed [W-1:0] sd;
    logic [W-1:0] r;
    e  = eff_amt(amt, mode);
    sd = d;
    if (mode == 2) begin
      if (e == 0) r = d;
      else if (dir) r = (d >> e) | (d << (W - e));
      else r = (d << e) | (d >> (W - e));
    end else if (dir) begin
      if (mode == 1) r = sd >>> e;
      else r = d >> e;
    end else begin
      r = d << e;
    end
    return r;
  endfunction

  function automatic int n_steps(input int amt, input int mode, input int step);
    return (eff_amt(amt, mode) + step - 1) / step;
  endfunction

  // Issue one request with out_ready=1; check result, latency, single-cycle valid, in_ready after.
  task automatic do_op(input string tag, input logic [W-1:0] d, input int amt, input bit dir,
                       input int mode);
    int fa, fb, ca, cb;
    logic [W-1:0] da, db, exp;
    logic ra, rb;
    fa = 0; fb = 0; ca = 0; cb = 0; da = '0; db = '0; ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 20 && !(a_ready && b_ready); i++) tick();
    exp       = ref_shift(d, amt, dir, mode);
    out_ready = 1'b1;
    in_data   = d;
    in_amt    = SW'(amt);
    in_dir    = dir;
    in_mode   = 2'(mode);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_amt   = SW'($urandom);
    in_dir   = 1'($urandom);
    in_mode  = 2'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (a_valid) begin
        ca++;
        if (fa == 0) begin fa = k; da = a_data; end
      end
      if (b_valid) begin
        cb++;
        if (fb == 0) begin fb = k; db = b_data; end
      end
      if (fa != 0 && k == fa + 1) ra = a_ready;
      if (fb != 0 && k == fb + 1) rb = b_ready;
      tick();
    end
    check({tag, " s1 latency"}, fa, 1 + n_steps(amt, mode, 1));
    check({tag, " s1 data"}, da, exp);
    check({tag, " s1 valid cycles"}, ca, 1);
    check({tag, " s1 ready after"}, ra, 1);
    check({tag, " s3 latency"}, fb, 1 + n_steps(amt, mode, 3));
    check({tag, " s3 data"}, db, exp);
    check({tag, " s3 valid cycles"}, cb, 1);
    check({tag, " s3 ready after"}, rb, 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_dir = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_mode = '0;

    // Reset values
    tick();
    tick();
    check("rst in_ready", a_ready, 0);
    check("rst out_valid", a_valid, 0);
    check("rst out_data", a_data, 0);
    check("rst s3 in_ready", b_ready, 0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", a_ready, 1);
    check("post-rst s3 in_ready", b_ready, 1);

    // Directed cases
    check("model AD<<2", ref_shift(8'hAD, 2, 0, 0), 8'hB4);
    do_op("lsl2", 8'hAD, 2, 0, 0);
    do_op("asr2", 8'hAD, 2, 1, 1);
    do_op("lsr2", 8'hAD, 2, 1, 0);
    do_op("rsv2", 8'hAD, 2, 1, 3);
    do_op("ror9", 8'hAD, 9, 1, 2);
    do_op("amt0", 8'hAD, 0, 1, 1);
    do_op("lsr12", 8'hAD, 12, 1, 0);
    do_op("asr12", 8'hAD, 12, 1, 1);
    do_op("asl8", 8'h81, 8, 0, 1);
    do_op("rol15", 8'h3C, 15, 0, 2);
    do_op("lsl7", 8'h01, 7, 0, 0);

    // Random cases
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), W'($urandom), int'($urandom_range(0, 2 * W - 1)),
            1'($urandom), int'($urandom_range(0, 3)));
    end

    // Backpressure: result held, requests ignored
    out_ready = 1'b0;
    in_data = 8'hAD; in_amt = 1; in_dir = 1'b0; in_mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !a_valid; i++) tick();
    for (int i = 0; i < 4; i++) begin
      check("bp valid", a_valid, 1);
      check("bp data", a_data, 8'h5A);
      check("bp in_ready", a_ready, 0);
      check("bp s3 data", b_data, 8'h5A);
      in_valid = 1'b1; in_data = 8'h00; in_amt = 0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp still valid", a_valid, 1);
    tick();
    check("bp drained valid", a_valid, 0);
    check("bp drained ready", a_ready, 1);
    check("bp s3 drained ready", b_ready, 1);

    // Flush in the second SHIFT cycle
    in_data = 8'hAD; in_amt = 5; in_dir = 1'b0; in_mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush ready", a_ready, 1);
    check("flush valid", a_valid, 0);
    check("flush s3 ready", b_ready, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_valid || b_valid) cnt++;
      tick();
    end
    check("flush no valid", cnt, 0);

    // Flush together with a request in IDLE
    flush = 1'b1; in_valid = 1'b1; in_amt = 0;
    #1;
    check("flush blocks ready", a_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_valid || b_valid) cnt++;
      tick();
    end
    check("flush+req ignored", cnt, 0);

    // Reset mid-SHIFT
    in_data = 8'hAD; in_amt = 12; in_dir = 1'b1; in_mode = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst-mid valid", a_valid, 0);
    check("rst-mid data", a_data, 0);
    check("rst-mid ready", a_ready, 0);
    check("rst-mid s3 data", b_data, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_valid || b_valid) cnt++;
      tick();
    end
    check("rst-mid no valid", cnt, 0);
    check("rst-mid ready after", a_ready, 1);

    do_op("final", 8'hC3, 3, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
